clock_set_ctrl: RTL and testbench

Time-setting controller for the 1 Hz calendar/time counter. It owns the counter's parallel load port and shares it between two requesters: a two-button user edit sequence and an external time-sync source. It snapshots the running time, lets the user step and increment fields in a shadow register, and issues a single-cycle load on commit. It sits between the debounced button logic and the timekeeping counter, in the clk_1Hz domain.

---
 rtl/clock_pkg.sv | 71 +++++++
 rtl/clock_set_ctrl_if.sv | 33 +++
 rtl/field_wrap_inc.sv | 26 ++
 rtl/clock_set_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-setting controller:
//   - field index constants FLD_YEAR..FLD_SECOND (also the sel_field encoding)
//   - per-field MIN/MAX range constants and lookup functions
//   - controller state encoding
//   - 48-bit packed time type laid out as {year,month,day,hour,minute,second}
// -----------------------------------------------------------------------------
package clock_pkg;

    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FLD_YEAR   = 3'd0;
    localparam logic [2:0] FLD_MONTH  = 3'd1;
    localparam logic [2:0] FLD_DAY    = 3'd2;
    localparam logic [2:0] FLD_HOUR   = 3'd3;
    localparam logic [2:0] FLD_MINUTE = 3'd4;
    localparam logic [2:0] FLD_SECOND = 3'd5;

    // Day range follows the counter's 30-day month model.
    localparam logic [7:0] YEAR_MIN   = 8'd0;
    localparam logic [7:0] YEAR_MAX   = 8'd99;
    localparam logic [7:0] MONTH_MIN  = 8'd1;
    localparam logic [7:0] MONTH_MAX  = 8'd12;
    localparam logic [7:0] DAY_MIN    = 8'd1;
    localparam logic [7:0] DAY_MAX    = 8'd30;
    localparam logic [7:0] HOUR_MIN   = 8'd0;
    localparam logic [7:0] HOUR_MAX   = 8'd23;
    localparam logic [7:0] MINUTE_MIN = 8'd0;
    localparam logic [7:0] MINUTE_MAX = 8'd59;
    localparam logic [7:0] SECOND_MIN = 8'd0;
    localparam logic [7:0] SECOND_MAX = 8'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] year;
        logic [7:0] month;
        logic [7:0] day;
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } time_t;

    function automatic logic [7:0] fld_min(input logic [2:0] fld);
        case (fld)
            FLD_YEAR:   return YEAR_MIN;
            FLD_MONTH:  return MONTH_MIN;
            FLD_DAY:    return DAY_MIN;
            FLD_HOUR:   return HOUR_MIN;
            FLD_MINUTE: return MINUTE_MIN;
            default:    return SECOND_MIN;
        endcase
    endfunction

    function automatic logic [7:0] fld_max(input logic [2:0] fld);
        case (fld)
            FLD_YEAR:   return YEAR_MAX;
            FLD_MONTH:  return MONTH_MAX;
            FLD_DAY:    return DAY_MAX;
            FLD_HOUR:   return HOUR_MAX;
            FLD_MINUTE: return MINUTE_MAX;
            default:    return SECOND_MAX;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_if
// Load bus to the timekeeping counter plus the time-sync handshake.
//   load, load_*          : one-cycle parallel load strobe and values
//   sync_req, sync_time   : sync request level and {Y,M,D,h,m,s} payload
//   sync_ack, sync_err    : one-cycle acknowledge, error flag on rejection
// master = the controller, slave = counter / sync source side.
// -----------------------------------------------------------------------------
interface clock_set_ctrl_if;
    logic        load;
    logic [7:0]  load_year;
    logic [7:0]  load_month;
    logic [7:0]  load_day;
    logic [7:0]  load_hour;
    logic [7:0]  load_minute;
    logic [7:0]  load_second;
    logic        sync_req;
    logic [47:0] sync_time;
    logic        sync_ack;
    logic        sync_err;

    modport master (
        output load, load_year, load_month, load_day, load_hour, load_minute, load_second,
        output sync_ack, sync_err,
        input  sync_req, sync_time
    );

    modport slave (
        input  load, load_year, load_month, load_day, load_hour, load_minute, load_second,
        input  sync_ack, sync_err,
        output sync_req, sync_time
    );
endinterface

// File: rtl/field_wrap_inc.sv
// -----------------------------------------------------------------------------
// field_wrap_inc
// Combinational per-field helper.
//   fld      in  3  field index (FLD_YEAR..FLD_SECOND)
//   val      in  8  current field value
//   nxt      out 8  val+1, wrapping max->min; out-of-range values go to min
//   in_range out 1  val lies within [min,max] of the field
// -----------------------------------------------------------------------------
module field_wrap_inc
    import clock_pkg::*;
(
    input  logic [2:0] fld,
    input  logic [7:0] val,
    output logic [7:0] nxt,
    output logic       in_range
);
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo       = fld_min(fld);
        hi       = fld_max(fld);
        in_range = (val >= lo) && (val <= hi);
        nxt      = (val >= hi || val < lo) ? lo : val + 8'd1;
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller owning the counter's parallel load port. Arbitrates
// between the two-button edit sequence (snapshot -> step/increment fields in a
// shadow register -> one-cycle load on commit) and an external time-sync
// request, which is range-checked before it is loaded.
// Ports:
//   clk_1Hz, rst (async, active-low)
//   btn_mode, btn_inc   : debounced single-cycle button pulses
//   cur_*               : live counter values, snapshotted on edit entry
//   bus (master)        : load strobe/values and sync handshake
//   editing, sel_field  : edit status and field under edit
// Parameter EDIT_TIMEOUT: idle cycles before an edit is abandoned.
// Optional feature macro EDIT_TIMEOUT_EN: enables the edit idle timeout.
// -----------------------------------------------------------------------------
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int EDIT_TIMEOUT = 30
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [7:0]       cur_year,
    input  logic [7:0]       cur_month,
    input  logic [7:0]       cur_day,
    input  logic [7:0]       cur_hour,
    input  logic [7:0]       cur_minute,
    input  logic [7:0]       cur_second,
    clock_set_ctrl_if.master bus,
    output logic             editing,
    output logic [2:0]       sel_field
);
    state_t     state_q, state_d;
    logic       load_q, load_d;
    logic       sync_ack_q, sync_ack_d;
    logic       sync_err_q, sync_err_d;
    logic       editing_q, editing_d;
    logic [2:0] sel_field_q, sel_field_d;
    logic [7:0] shadow_q [NUM_FIELDS];
    logic [7:0] shadow_d [NUM_FIELDS];
    logic [7:0] load_val_q [NUM_FIELDS];
    logic [7:0] load_val_d [NUM_FIELDS];

    logic [7:0] cur_arr  [NUM_FIELDS];
    logic [7:0] sync_arr [NUM_FIELDS];
    logic [7:0] snap_arr [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] snap_ok;
    logic [NUM_FIELDS-1:0] sync_ok;
    logic [7:0] snap_nxt_unused [NUM_FIELDS];
    logic [7:0] sync_nxt_unused [NUM_FIELDS];
    logic [7:0] edit_val;
    logic [7:0] edit_nxt;
    logic       edit_rng_unused;
    time_t      sync_t;

`ifdef EDIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(EDIT_TIMEOUT - 1);
    logic [15:0] idle_cnt_q, idle_cnt_d;
`else
    localparam int unused_edit_timeout = EDIT_TIMEOUT;
`endif

    assign sync_t      = bus.sync_time;
    assign cur_arr[0]  = cur_year;
    assign cur_arr[1]  = cur_month;
    assign cur_arr[2]  = cur_day;
    assign cur_arr[3]  = cur_hour;
    assign cur_arr[4]  = cur_minute;
    assign cur_arr[5]  = cur_second;
    assign sync_arr[0] = sync_t.year;
    assign sync_arr[1] = sync_t.month;
    assign sync_arr[2] = sync_t.day;
    assign sync_arr[3] = sync_t.hour;
    assign sync_arr[4] = sync_t.minute;
    assign sync_arr[5] = sync_t.second;

    // One range checker per field for the snapshot clamp and the sync check.
    for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_fld
        field_wrap_inc u_snap (
            .fld(3'(i)), .val(cur_arr[i]), .nxt(snap_nxt_unused[i]), .in_range(snap_ok[i])
        );
        field_wrap_inc u_sync (
            .fld(3'(i)), .val(sync_arr[i]), .nxt(sync_nxt_unused[i]), .in_range(sync_ok[i])
        );
        assign snap_arr[i] = snap_ok[i] ? cur_arr[i] : fld_min(3'(i));
    end

    always_comb begin
        edit_val = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (sel_field_q == 3'(i)) edit_val = shadow_q[i];
        end
    end

    field_wrap_inc u_edit (
        .fld(sel_field_q), .val(edit_val), .nxt(edit_nxt), .in_range(edit_rng_unused)
    );

    always_comb begin
        state_d     = state_q;
        load_d      = 1'b0;
        sync_ack_d  = 1'b0;
        sync_err_d  = 1'b0;
        editing_d   = editing_q;
        sel_field_d = sel_field_q;
        shadow_d    = shadow_q;
        load_val_d  = load_val_q;
`ifdef EDIT_TIMEOUT_EN
        idle_cnt_d  = idle_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // A request still high in the ack cycle is the one just served.
                if (bus.sync_req && !sync_ack_q) begin
                    sync_ack_d = 1'b1;
                    if (&sync_ok) begin
                        load_d     = 1'b1;
                        load_val_d = sync_arr;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end else if (btn_mode) begin
                    state_d     = EDIT;
                    editing_d   = 1'b1;
                    sel_field_d = FLD_YEAR;
                    shadow_d    = snap_arr;
`ifdef EDIT_TIMEOUT_EN
                    idle_cnt_d  = '0;
`endif
                end
            end
            EDIT: begin
                if (btn_mode) begin
                    if (sel_field_q == FLD_SECOND) begin
                        state_d     = COMMIT;
                        load_d      = 1'b1;
                        load_val_d  = shadow_q;
                        editing_d   = 1'b0;
                        sel_field_d = FLD_YEAR;
                    end else begin
                        sel_field_d = sel_field_q + 3'd1;
                    end
`ifdef EDIT_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end else if (btn_inc) begin
                    for (int i = 0; i < NUM_FIELDS; i++) begin
                        if (sel_field_q == 3'(i)) shadow_d[i] = edit_nxt;
                    end
`ifdef EDIT_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
`ifdef EDIT_TIMEOUT_EN
                else if (idle_cnt_q >= TIMEOUT_LAST) begin
                    state_d     = IDLE;
                    editing_d   = 1'b0;
                    sel_field_d = FLD_YEAR;
                    for (int i = 0; i < NUM_FIELDS; i++) shadow_d[i] = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
`endif
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                editing_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            sync_ack_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            editing_q   <= 1'b0;
            sel_field_q <= '0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow_q[i]   <= '0;
                load_val_q[i] <= '0;
            end
`ifdef EDIT_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            sync_ack_q  <= sync_ack_d;
            sync_err_q  <= sync_err_d;
            editing_q   <= editing_d;
            sel_field_q <= sel_field_d;
            shadow_q    <= shadow_d;
            load_val_q  <= load_val_d;
`ifdef EDIT_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign bus.load        = load_q;
    assign bus.sync_ack    = sync_ack_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.load_year   = load_val_q[0];
    assign bus.load_month  = load_val_q[1];
    assign bus.load_day    = load_val_q[2];
    assign bus.load_hour   = load_val_q[3];
    assign bus.load_minute = load_val_q[4];
    assign bus.load_second = load_val_q[5];
    assign editing         = editing_q;
    assign sel_field       = sel_field_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl: reset, sync load/reject, sync request
// held too long, edit sequence with wrap and clamp, mode+inc collision,
// sync deferred during edit, reset mid-edit, and edit persistence or timeout
// (EDIT_TIMEOUT_EN, with EDIT_TIMEOUT=3).
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;
    logic        clk_1Hz = 1'b0;
    logic        rst = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic [47:0] cur_all = '0;
    logic        editing;
    logic [2:0]  sel_field;
    logic [47:0] load_all;
    int          n_checks = 0;
    int          n_fails = 0;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.EDIT_TIMEOUT(3)) dut (
        .clk_1Hz   (clk_1Hz),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_year  (cur_all[47:40]),
        .cur_month (cur_all[39:32]),
        .cur_day   (cur_all[31:24]),
        .cur_hour  (cur_all[23:16]),
        .cur_minute(cur_all[15:8]),
        .cur_second(cur_all[7:0]),
        .bus       (bus.master),
        .editing   (editing),
        .sel_field (sel_field)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    assign load_all = {bus.load_year, bus.load_month, bus.load_day,
                       bus.load_hour, bus.load_minute, bus.load_second};

    task automatic step();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1; step(); btn_mode = 1'b0;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
    endtask

    task automatic pulse_both();
        btn_mode = 1'b1; btn_inc = 1'b1; step(); btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; step(); step();
        n_checks++; if (bus.load !== 1'b0) begin n_fails++; $display("FAIL reset_load: got %0b want 0", bus.load); end
        n_checks++; if (load_all !== 48'h0) begin n_fails++; $display("FAIL reset_load_vals: got %h want 0", load_all); end
        n_checks++; if (editing !== 1'b0) begin n_fails++; $display("FAIL reset_editing: got %0b want 0", editing); end
        n_checks++; if (sel_field !== 3'd0) begin n_fails++; $display("FAIL reset_sel: got %0d want 0", sel_field); end
        n_checks++; if (bus.sync_ack !== 1'b0) begin n_fails++; $display("FAIL reset_ack: got %0b want 0", bus.sync_ack); end
        n_checks++; if (bus.sync_err !== 1'b0) begin n_fails++; $display("FAIL reset_err: got %0b want 0", bus.sync_err); end
        @(negedge clk_1Hz); rst = 1'b1;
        step();
    endtask

    task automatic test_sync_ok();
        logic [47:0] t0 = {8'd25, 8'd6, 8'd15, 8'd12, 8'd30, 8'd0};
        logic [47:0] t1 = {8'd99, 8'd12, 8'd30, 8'd23, 8'd59, 8'd59};
        bus.sync_time = t0; bus.sync_req = 1'b1; step();
        n_checks++; if (bus.load !== 1'b1) begin n_fails++; $display("FAIL sync_load: got %0b want 1", bus.load); end
        n_checks++; if (bus.sync_ack !== 1'b1) begin n_fails++; $display("FAIL sync_ack: got %0b want 1", bus.sync_ack); end
        n_checks++; if (bus.sync_err !== 1'b0) begin n_fails++; $display("FAIL sync_err_clear: got %0b want 0", bus.sync_err); end
        n_checks++; if (load_all !== t0) begin n_fails++; $display("FAIL sync_vals: got %h want %h", load_all, t0); end
        bus.sync_req = 1'b0; step();
        n_checks++; if (bus.load !== 1'b0) begin n_fails++; $display("FAIL sync_load_1cyc: got %0b want 0", bus.load); end
        n_checks++; if (bus.sync_ack !== 1'b0) begin n_fails++; $display("FAIL sync_ack_1cyc: got %0b want 0", bus.sync_ack); end
        bus.sync_time = t1; bus.sync_req = 1'b1; step();
        n_checks++; if (bus.load !== 1'b1 || bus.sync_err !== 1'b0) begin n_fails++; $display("FAIL sync_max_ok: load=%0b err=%0b want 1/0", bus.load, bus.sync_err); end
        n_checks++; if (load_all !== t1) begin n_fails++; $display("FAIL sync_max_vals: got %h want %h", load_all, t1); end
        bus.sync_req = 1'b0; step();
    endtask

    task automatic test_sync_err();
        logic [47:0] bad [7] = '{
            {8'd25, 8'd13, 8'd15, 8'd12, 8'd30, 8'd0},
            {8'd100, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0},
            {8'd25, 8'd6, 8'd31, 8'd0, 8'd0, 8'd0},
            {8'd25, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0},
            {8'd25, 8'd6, 8'd15, 8'd24, 8'd0, 8'd0},
            {8'd25, 8'd6, 8'd15, 8'd12, 8'd60, 8'd0},
            {8'd25, 8'd0, 8'd15, 8'd12, 8'd30, 8'd60}
        };
        for (int k = 0; k < 7; k++) begin
            bus.sync_time = bad[k]; bus.sync_req = 1'b1; step();
            n_checks++; if (bus.sync_ack !== 1'b1 || bus.sync_err !== 1'b1 || bus.load !== 1'b0) begin
                n_fails++; $display("FAIL sync_reject_%0d: ack=%0b err=%0b load=%0b want 1/1/0", k, bus.sync_ack, bus.sync_err, bus.load);
            end
            bus.sync_req = 1'b0; step();
            n_checks++; if (bus.sync_err !== 1'b0) begin n_fails++; $display("FAIL sync_err_pulse_%0d: got %0b want 0", k, bus.sync_err); end
        end
    endtask

    task automatic test_sync_hold();
        bus.sync_time = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6}; bus.sync_req = 1'b1; step();
        n_checks++; if (bus.sync_ack !== 1'b1) begin n_fails++; $display("FAIL hold_ack0: got %0b want 1", bus.sync_ack); end
        step();
        n_checks++; if (bus.sync_ack !== 1'b0 || bus.load !== 1'b0) begin n_fails++; $display("FAIL hold_gap: ack=%0b load=%0b want 0/0", bus.sync_ack, bus.load); end
        step();
        n_checks++; if (bus.sync_ack !== 1'b1 || bus.load !== 1'b1) begin n_fails++; $display("FAIL hold_new_req: ack=%0b load=%0b want 1/1", bus.sync_ack, bus.load); end
        bus.sync_req = 1'b0; step();
    endtask

    task automatic test_edit();
        logic [47:0] exp_v = {8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd59};
        cur_all = {8'd0, 8'd0, 8'd0, 8'd23, 8'd59, 8'd59};
        pulse_mode();
        n_checks++; if (editing !== 1'b1 || sel_field !== 3'd0) begin n_fails++; $display("FAIL edit_enter: editing=%0b sel=%0d want 1/0", editing, sel_field); end
        cur_all = {8'd50, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        pulse_mode(); pulse_mode(); pulse_mode();
        n_checks++; if (sel_field !== 3'd3) begin n_fails++; $display("FAIL edit_sel_hour: got %0d want 3", sel_field); end
        pulse_inc(); pulse_mode();
        n_checks++; if (sel_field !== 3'd4) begin n_fails++; $display("FAIL edit_sel_minute: got %0d want 4", sel_field); end
        pulse_inc(); pulse_inc(); pulse_mode();
        n_checks++; if (sel_field !== 3'd5 || bus.load !== 1'b0) begin n_fails++; $display("FAIL edit_sel_second: sel=%0d load=%0b want 5/0", sel_field, bus.load); end
        pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || editing !== 1'b0 || bus.sync_ack !== 1'b0) begin
            n_fails++; $display("FAIL edit_commit: load=%0b editing=%0b ack=%0b want 1/0/0", bus.load, editing, bus.sync_ack);
        end
        n_checks++; if (load_all !== exp_v) begin n_fails++; $display("FAIL edit_commit_vals: got %h want %h", load_all, exp_v); end
        step();
        n_checks++; if (bus.load !== 1'b0 || editing !== 1'b0) begin n_fails++; $display("FAIL edit_after_commit: load=%0b editing=%0b want 0/0", bus.load, editing); end
    endtask

    task automatic test_wrap_clamp();
        logic [47:0] exp_w = {8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
        logic [47:0] exp_c = {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
        cur_all = {8'd99, 8'd12, 8'd30, 8'd0, 8'd0, 8'd0};
        pulse_mode();
        pulse_inc(); pulse_mode(); pulse_inc(); pulse_mode(); pulse_inc(); pulse_mode(); pulse_inc();
        pulse_mode(); pulse_mode(); pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || load_all !== exp_w) begin n_fails++; $display("FAIL wrap_vals: load=%0b got %h want %h", bus.load, load_all, exp_w); end
        step();
        cur_all = {8'd120, 8'd0, 8'd45, 8'd24, 8'd60, 8'd61};
        pulse_mode();
        for (int k = 0; k < 6; k++) pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || load_all !== exp_c) begin n_fails++; $display("FAIL clamp_vals: load=%0b got %h want %h", bus.load, load_all, exp_c); end
        step();
    endtask

    task automatic test_mode_inc_same();
        logic [47:0] exp_v = {8'd5, 8'd12, 8'd7, 8'd1, 8'd2, 8'd3};
        cur_all = exp_v;
        pulse_mode(); pulse_mode();
        pulse_both();
        n_checks++; if (sel_field !== 3'd2) begin n_fails++; $display("FAIL both_sel: got %0d want 2", sel_field); end
        pulse_mode(); pulse_mode(); pulse_mode(); pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || load_all !== exp_v) begin n_fails++; $display("FAIL both_month_kept: load=%0b got %h want %h", bus.load, load_all, exp_v); end
        step();
    endtask

    task automatic test_edit_sync();
        logic [47:0] exp_e = {8'd10, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        logic [47:0] exp_s = {8'd30, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        cur_all = exp_e;
        pulse_mode();
        bus.sync_time = exp_s; bus.sync_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pulse_mode();
            n_checks++; if (bus.sync_ack !== 1'b0) begin n_fails++; $display("FAIL edit_no_ack_%0d: got %0b want 0", k, bus.sync_ack); end
        end
        pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || bus.sync_ack !== 1'b0 || load_all !== exp_e) begin
            n_fails++; $display("FAIL edit_sync_commit: load=%0b ack=%0b vals=%h want 1/0/%h", bus.load, bus.sync_ack, load_all, exp_e);
        end
        step();
        n_checks++; if (bus.load !== 1'b0 || bus.sync_ack !== 1'b0) begin n_fails++; $display("FAIL edit_sync_gap: load=%0b ack=%0b want 0/0", bus.load, bus.sync_ack); end
        step();
        n_checks++; if (bus.load !== 1'b1 || bus.sync_ack !== 1'b1 || load_all !== exp_s) begin
            n_fails++; $display("FAIL edit_sync_served: load=%0b ack=%0b vals=%h want 1/1/%h", bus.load, bus.sync_ack, load_all, exp_s);
        end
        bus.sync_req = 1'b0; step();
    endtask

    task automatic test_reset_mid_edit();
        logic [47:0] exp_v = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        cur_all = exp_v;
        pulse_mode(); pulse_inc();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (editing !== 1'b0 || bus.load !== 1'b0 || sel_field !== 3'd0) begin
            n_fails++; $display("FAIL rst_mid_edit: editing=%0b load=%0b sel=%0d want 0/0/0", editing, bus.load, sel_field);
        end
        @(negedge clk_1Hz); rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus.load !== 1'b0 || editing !== 1'b0) begin n_fails++; $display("FAIL rst_quiet_%0d: load=%0b editing=%0b want 0/0", k, bus.load, editing); end
        end
        pulse_mode();
        for (int k = 0; k < 6; k++) pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || load_all !== exp_v) begin n_fails++; $display("FAIL rst_resnap: load=%0b got %h want %h", bus.load, load_all, exp_v); end
        step();
    endtask

    task automatic test_timeout();
        cur_all = {8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
`ifdef EDIT_TIMEOUT_EN
        pulse_mode();
        step(); step();
        n_checks++; if (editing !== 1'b1) begin n_fails++; $display("FAIL timeout_early: editing=%0b want 1", editing); end
        step();
        n_checks++; if (editing !== 1'b0 || bus.load !== 1'b0) begin n_fails++; $display("FAIL timeout_abort: editing=%0b load=%0b want 0/0", editing, bus.load); end
        pulse_mode();
        step(); pulse_inc(); step(); step();
        n_checks++; if (editing !== 1'b1) begin n_fails++; $display("FAIL timeout_restart: editing=%0b want 1", editing); end
        step();
        n_checks++; if (editing !== 1'b0 || bus.load !== 1'b0) begin n_fails++; $display("FAIL timeout_abort2: editing=%0b load=%0b want 0/0", editing, bus.load); end
        step();
        n_checks++; if (bus.load !== 1'b0) begin n_fails++; $display("FAIL timeout_no_load: load=%0b want 0", bus.load); end
`else
        pulse_mode();
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++; if (bus.load !== 1'b0 || editing !== 1'b1) begin n_fails++; $display("FAIL persist_%0d: load=%0b editing=%0b want 0/1", k, bus.load, editing); end
        end
        for (int k = 0; k < 6; k++) pulse_mode();
        n_checks++; if (bus.load !== 1'b1 || load_all !== 48'h070707070707) begin n_fails++; $display("FAIL persist_commit: load=%0b got %h", bus.load, load_all); end
        step();
`endif
    endtask

    initial begin
        bus.sync_req  = 1'b0;
        bus.sync_time = '0;
        test_reset();
        test_sync_ok();
        test_sync_err();
        test_sync_hold();
        test_edit();
        test_wrap_clamp();
        test_mode_inc_same();
        test_edit_sync();
        test_reset_mid_edit();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
